// File: rtl/cnt_seq.sv
// cnt_seq: run controller for an external mod-11 counter (0..10).
// A run loads PRESET into the counter, then counts CYCLES carry-outs
// (0 meaning 2^W_CYC) before pulsing DONE. PAUSE freezes the counter and
// ABORT clears it. All outputs are decoded from state and registers only,
// so no input reaches an output without passing through a flop.

module cnt_seq #(
    parameter int W_CYC = 4
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [3:0]       preset,
    input  logic [W_CYC-1:0] cycles,
    input  logic             co,
    output logic             cnt_mr_n,
    output logic             cnt_load_n,
    output logic             cnt_en,
    output logic [3:0]       cnt_d,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W_CYC-1:0] wraps
);

    typedef enum logic [2:0] {
        S_CLR  = 3'd0,
        S_IDLE = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_HOLD = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [3:0]       PRESET_MAX = 4'd10;
    localparam logic [W_CYC-1:0] WRAP_ONE   = {{(W_CYC-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           nextState;
    logic [3:0]       presetR;
    logic [W_CYC-1:0] cycR;
    logic [W_CYC-1:0] wrapsR;
    logic [W_CYC-1:0] wrapsInc;
    logic             errR;
    logic             startOk;
    logic             startBad;
    logic             lastWrap;
    logic             abortable;

    // The truncated increment makes cycR==0 mean 2^W_CYC: the wrap count
    // rolls over to zero on exactly the 2^W_CYC-th carry.
    assign wrapsInc  = wrapsR + WRAP_ONE;
    assign startOk   = start && (preset <= PRESET_MAX);
    assign startBad  = start && (preset > PRESET_MAX);
    assign lastWrap  = co && (wrapsInc == cycR);
    assign abortable = (state == S_LOAD) || (state == S_RUN) ||
                       (state == S_HOLD) || (state == S_DONE);

    // State register; mr forces CLR regardless of any other input.
    always_ff @(posedge clk) begin
        if (mr) begin
            state <= S_CLR;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; completion beats pause, abort beats everything.
    always_comb begin
        nextState = state;
        case (state)
            S_CLR:   nextState = S_IDLE;
            S_IDLE:  if (startOk) nextState = S_LOAD;
            S_LOAD:  nextState = S_RUN;
            S_RUN: begin
                if (lastWrap) begin
                    nextState = S_DONE;
                end else if (pause) begin
                    nextState = S_HOLD;
                end
            end
            S_HOLD:  if (!pause) nextState = S_RUN;
            S_DONE:  nextState = S_IDLE;
            default: nextState = S_CLR;
        endcase
        if (abortable && abort) begin
            nextState = S_CLR;
        end
    end

    // Run parameters, wrap counter and the error pulse flop.
    always_ff @(posedge clk) begin
        if (mr) begin
            presetR <= 4'd0;
            cycR    <= '0;
            wrapsR  <= '0;
            errR    <= 1'b0;
        end else begin
            errR <= (state == S_IDLE) && startBad;
            case (state)
                S_CLR: wrapsR <= '0;
                S_IDLE: begin
                    if (startOk) begin
                        presetR <= preset;
                        cycR    <= cycles;
                        wrapsR  <= '0;
                    end
                end
                S_RUN: begin
                    if (co && !abort) begin
                        wrapsR <= wrapsInc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore output decode for the counter controls and status flags.
    always_comb begin
        cnt_mr_n   = 1'b1;
        cnt_load_n = 1'b1;
        cnt_en     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_CLR:  cnt_mr_n = 1'b0;
            S_LOAD: begin
                cnt_load_n = 1'b0;
                busy       = 1'b1;
            end
            S_RUN: begin
                cnt_en = 1'b1;
                busy   = 1'b1;
            end
            S_HOLD: busy = 1'b1;
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign cnt_d = presetR;
    assign err   = errR;
    assign wraps = wrapsR;

endmodule

// File: tb/tb_cnt_seq.sv
// tb_cnt_seq: directed bench pairing cnt_seq with a mod-11 counter model.
// Cycle numbers count edges from the START sample edge: the cycle that
// follows that edge is cycle 1 (LOAD), the next is cycle 2 (first RUN).

module tb_cnt_seq;

    logic       clk;
    logic       mr;
    logic       start;
    logic       pause;
    logic       abort;
    logic [3:0] preset;
    logic [3:0] cycles;
    logic       co;
    logic       cnt_mr_n;
    logic       cnt_load_n;
    logic       cnt_en;
    logic [3:0] cnt_d;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] wraps;
    logic [3:0] q;

    int errorCount = 0;
    int checkCount = 0;
    int cyc = 0;
    int doneAt;
    int busyHits;

    cnt_seq #(.W_CYC(4)) dut (
        .clk        (clk),
        .mr         (mr),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .preset     (preset),
        .cycles     (cycles),
        .co         (co),
        .cnt_mr_n   (cnt_mr_n),
        .cnt_load_n (cnt_load_n),
        .cnt_en     (cnt_en),
        .cnt_d      (cnt_d),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wraps      (wraps)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mod-11 counter: clear beats load beats count.
    always_ff @(posedge clk) begin
        if (!cnt_mr_n) begin
            q <= 4'd0;
        end else if (!cnt_load_n) begin
            q <= cnt_d;
        end else if (cnt_en) begin
            q <= (q == 4'd10) ? 4'd0 : q + 4'd1;
        end
    end

    assign co = cnt_en && (q == 4'd10);

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic a,
                                 input logic [3:0] pr, input logic [3:0] cy);
        start  = s;
        pause  = p;
        abort  = a;
        preset = pr;
        cycles = cy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic startRun(input logic [3:0] pr, input logic [3:0] cy);
        applyStimulus(1'b1, 1'b0, 1'b0, pr, cy);
        cyc = 0;
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, pr, cy);
    endtask

    task automatic waitDone(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Safety net in case a wait outside the bounded helpers stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        mr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        step();
        checkOutput("rst_mr_n", cnt_mr_n, 0);
        checkOutput("rst_load_n", cnt_load_n, 1);
        checkOutput("rst_en", cnt_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_wraps", wraps, 0);
        checkOutput("rst_q", q, 0);
        mr = 1'b0;
        step();
        checkOutput("idle_mr_n", cnt_mr_n, 1);
        checkOutput("idle_busy", busy, 0);

        // Basic run: preset 8, one wrap; START during DONE is dropped.
        startRun(4'd8, 4'd1);
        checkOutput("s1_load_n", cnt_load_n, 0);
        checkOutput("s1_load_d", cnt_d, 8);
        checkOutput("s1_load_en", cnt_en, 0);
        checkOutput("s1_load_busy", busy, 1);
        step();
        checkOutput("s1_c2_en", cnt_en, 1);
        checkOutput("s1_c2_q", q, 8);
        step();
        checkOutput("s1_c3_q", q, 9);
        step();
        checkOutput("s1_c4_q", q, 10);
        checkOutput("s1_c4_co", co, 1);
        step();
        checkOutput("s1_c5_done", done, 1);
        checkOutput("s1_c5_wraps", wraps, 1);
        checkOutput("s1_c5_q", q, 0);
        checkOutput("s1_c5_busy", busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 4'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd2, 4'd1);
        checkOutput("s1_c6_done", done, 0);
        checkOutput("s1_c6_busy", busy, 0);
        checkOutput("s1_c6_load_n", cnt_load_n, 1);
        checkOutput("s1_c6_wraps", wraps, 1);

        // Two wraps from preset 0.
        startRun(4'd0, 4'd2);
        waitDone(doneAt);
        checkOutput("s2_done_cyc", doneAt, 24);
        checkOutput("s2_wraps", wraps, 2);
        checkOutput("s2_busy", busy, 0);
        step();

        // Pause for five sampled edges stretches the run by five cycles.
        startRun(4'd8, 4'd1);
        step();
        pause = 1'b1;
        step();
        checkOutput("s3_hold_en", cnt_en, 0);
        checkOutput("s3_hold_q", q, 9);
        checkOutput("s3_hold_busy", busy, 1);
        for (int i = 0; i < 4; i++) step();
        checkOutput("s3_c7_q", q, 9);
        pause = 1'b0;
        waitDone(doneAt);
        checkOutput("s3_done_cyc", doneAt, 10);
        step();

        // Abort mid-run at Q=5.
        startRun(4'd0, 4'd1);
        for (int i = 0; i < 6; i++) step();
        checkOutput("s4_q5", q, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("s4_clr_mr_n", cnt_mr_n, 0);
        checkOutput("s4_clr_busy", busy, 0);
        checkOutput("s4_clr_done", done, 0);
        step();
        checkOutput("s4_q0", q, 0);
        checkOutput("s4_idle_mr_n", cnt_mr_n, 1);
        checkOutput("s4_idle_done", done, 0);
        checkOutput("s4_wraps", wraps, 0);

        // Illegal preset pulses ERR and latches nothing; legal run follows.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd11, 4'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd11, 4'd1);
        checkOutput("s5_err", err, 1);
        checkOutput("s5_busy", busy, 0);
        checkOutput("s5_load_n", cnt_load_n, 1);
        checkOutput("s5_cnt_d", cnt_d, 0);
        step();
        checkOutput("s5_err_clear", err, 0);
        startRun(4'd3, 4'd1);
        checkOutput("s5_load_d", cnt_d, 3);
        waitDone(doneAt);
        checkOutput("s5_done_cyc", doneAt, 10);
        step();

        // MR held for two edges mid-run.
        startRun(4'd9, 4'd3);
        for (int i = 0; i < 4; i++) step();
        checkOutput("s6_wraps_pre", wraps, 1);
        mr = 1'b1;
        step();
        checkOutput("s6_mr1_mr_n", cnt_mr_n, 0);
        checkOutput("s6_mr1_busy", busy, 0);
        step();
        checkOutput("s6_mr2_mr_n", cnt_mr_n, 0);
        checkOutput("s6_q", q, 0);
        checkOutput("s6_wraps", wraps, 0);
        checkOutput("s6_cnt_d", cnt_d, 0);
        mr = 1'b0;
        step();
        checkOutput("s6_idle_mr_n", cnt_mr_n, 1);
        checkOutput("s6_idle_busy", busy, 0);

        // START during RUN is ignored and not queued.
        startRun(4'd5, 4'd1);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
        waitDone(doneAt);
        checkOutput("s7_done_cyc", doneAt, 8);
        checkOutput("s7_wraps", wraps, 1);
        checkOutput("s7_cnt_d", cnt_d, 5);
        busyHits = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy !== 1'b0) busyHits++;
        end
        checkOutput("s7_no_queue", busyHits, 0);

        // Completion and PAUSE on the same edge: DONE wins.
        startRun(4'd8, 4'd1);
        for (int i = 0; i < 3; i++) step();
        checkOutput("s8_q10", q, 10);
        pause = 1'b1;
        step();
        pause = 1'b0;
        checkOutput("s8_done", done, 1);
        checkOutput("s8_busy", busy, 0);
        step();

        // CYCLES=0 means sixteen wraps; the count rolls over to zero.
        startRun(4'd10, 4'd0);
        waitDone(doneAt);
        checkOutput("s9_done_cyc", doneAt, 168);
        checkOutput("s9_wraps", wraps, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cnt_seq.md
CNT_SEQ -- requirements
Module: cnt_seq

Interface
REQ-001 Parameter: W_CYC, default 4, width of the CYCLES input and the WRAPS output.
REQ-002 CLK  in  1  single clock; all state changes on the rising edge.
REQ-003 MR  in  1  reset; synchronous, active-high.
REQ-004 START  in  1  run request; sampled only in IDLE.
REQ-005 PAUSE  in  1  level; freezes counting while high.
REQ-006 ABORT  in  1  cancels the run and clears the counter.
REQ-007 PRESET  in  4  counter start value; legal range 0..10.
REQ-008 CYCLES  in  W_CYC  number of counter wraps per run; 0 means 2^W_CYC.
REQ-009 CO  in  1  carry from the mod-11 counter; high when Q=10 and EN=1.
REQ-010 CNT_MR_N  out  1  counter clear, active-low.
REQ-011 CNT_LOAD_N  out  1  counter synchronous load, active-low.
REQ-012 CNT_EN  out  1  counter count enable.
REQ-013 CNT_D  out  4  counter load data.
REQ-014 BUSY  out  1  high in the LOAD, RUN and HOLD states.
REQ-015 DONE  out  1  one-cycle pulse at run completion.
REQ-016 ERR  out  1  one-cycle pulse when START arrives with an illegal PRESET.
REQ-017 WRAPS  out  W_CYC  number of CO events counted in the current run.

Function
REQ-018 The FSM SHALL have states CLR, IDLE, LOAD, RUN, HOLD, DONE; all outputs SHALL be Moore-decoded from state and registers, with no combinational path from input to output.
REQ-019 CLR: CNT_MR_N=0, WRAPS<=0; next state IDLE.
REQ-020 IDLE, START=1 and PRESET<=10: latch PRESET into preset_r and CYCLES into cyc_r, WRAPS<=0; next state LOAD.
REQ-021 IDLE, START=1 and PRESET>10: ERR=1 in the next cycle; stay in IDLE; latch nothing.
REQ-022 LOAD lasts exactly one cycle: CNT_LOAD_N=0, CNT_D=preset_r, CNT_EN=0; next state RUN.
REQ-023 CNT_D SHALL equal preset_r in every state.
REQ-024 RUN: CNT_EN=1; on each edge with CO=1, WRAPS<=WRAPS+1.
REQ-025 RUN, CO=1 and WRAPS+1 equals cyc_r (cyc_r=0 means 2^W_CYC): next state DONE; this completion SHALL take priority over PAUSE.
REQ-026 RUN, PAUSE=1 and no completion: next state HOLD; a CO on the same edge SHALL still be counted.
REQ-027 HOLD: CNT_EN=0 and CO ignored; next state RUN when PAUSE=0.
REQ-028 DONE: DONE=1 for one cycle; WRAPS holds its final value; next state IDLE; START in DONE is ignored.
REQ-029 ABORT=1 in LOAD, RUN, HOLD or DONE: next state CLR; ABORT SHALL take priority over every other transition.
REQ-030 ABORT in IDLE or CLR SHALL have no effect.
REQ-031 START outside IDLE SHALL be ignored, with no queuing.
REQ-032 WRAPS SHALL wrap modulo 2^W_CYC, which occurs only when cyc_r=0.
REQ-033 Latency: START sampled at edge 0 -> LOAD in cycle 1 -> RUN from cycle 2 -> counter Q=preset_r during cycle 2.

Reset
REQ-034 MR=1 at a rising edge: state<=CLR; preset_r, cyc_r and WRAPS <=0; DONE=ERR=0.
REQ-035 While MR stays high, the state SHALL remain CLR, with CNT_MR_N=0, CNT_LOAD_N=1, CNT_EN=0, BUSY=0.
REQ-036 The first edge with MR=0 SHALL move CLR to IDLE.
REQ-037 MR SHALL override ABORT, START and PAUSE in any state, including mid-run.

Verification
The bench pairs cnt_seq with a mod-11 counter model (0..10, CO=1 when Q=10 and EN=1, synchronous active-low load and clear).
REQ-038 PRESET=8, CYCLES=1, START pulse at edge 0 -> RUN in cycles 2-4 (Q=8,9,10), DONE=1 in cycle 5, WRAPS=1, Q=0 afterward.
REQ-039 PRESET=0, CYCLES=2 -> 22 RUN cycles, DONE=1 in cycle 24, WRAPS=2, BUSY low from cycle 24.
REQ-040 PRESET=8, CYCLES=1, PAUSE high for 5 cycles starting in cycle 3 -> Q holds at 9 in HOLD, DONE delayed by exactly 5 cycles to cycle 10.
REQ-041 ABORT during RUN at Q=5 -> CLR for one cycle with CNT_MR_N=0, Q=0, then IDLE; no DONE pulse; BUSY=0.
REQ-042 PRESET=11 with START -> ERR=1 for one cycle, no LOAD; then PRESET=3 with START -> normal run.
REQ-043 MR=1 mid-RUN for 2 cycles -> CNT_MR_N=0 on both, Q=0, WRAPS=0, then IDLE.
REQ-044 START during RUN -> no effect.
REQ-045 Simultaneous CO completion and PAUSE -> DONE is taken, not HOLD.
